vga_frame_checker: RTL and testbench
====================================

# vga_frame_checker

Passive sink for the game's VGA output bus: it samples HS/VS/BLANK_N and the 24-bit RGB stream at pixel rate and checks the sync timing. For every frame it produces a CRC-16 signature of the visible pixels, line/pixel counts and timing-error flags. It sits beside the VGA pins on the 50 MHz domain and is used for on-board self-check and regression of rendered screens (pre-game, in-game, victory, defeat).

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- H_TOTAL, 800, pixel clocks per line (HS falling edge to HS falling edge)
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel strobe; high one clk in two, in phase with the 25 MHz VGA clock rising edge; all other inputs are sampled only when pix_en=1
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low
- vga_blank_n  in  1  1 = visible pixel
- vga_r, vga_g, vga_b  in  8 each  pixel colour
- frame_valid  out  1  one-clk pulse when frame results update
- frame_crc  out  16  CRC of last completed frame
- active_lines  out  10  lines with ≥1 visible pixel in last frame
- last_line_pixels  out  11  visible pixel count of last non-empty line
- frame_count  out  16  completed frames, wraps 0xFFFF→0x0000
- err_hlen, err_vlen, err_htotal  out  1 each  per-frame error flags
- err_sticky  out  1  OR of all error flags since reset
- locked  out  1  timing stable

## Operation
- Sample register: on pix_en, capture hs/vs/blank_n/rgb; keep previous hs/vs. A falling edge is prev=1 and cur=0. Prev hs/vs reset to 1.
- FSM states: SEEK → ACQUIRE → RUN.
  - SEEK: ignore pixels; first VS falling edge → ACQUIRE, clear accumulators, no frame_valid.
  - ACQUIRE/RUN: accumulate; each VS falling edge closes the frame. ACQUIRE → RUN after the first closed frame. Closing a frame publishes the results, pulses frame_valid and increments frame_count.
- Pixel path (sample with blank_n=1, state≠SEEK):
  - line_pix += 1, saturating at 2047.
  - Fold the 24 bits {r,g,b}, MSB first, into the CRC in one cycle. CRC-16-CCITT: poly 0x1021, init 0xFFFF at frame start, no reflection, no final XOR.
- Line close (HS falling edge, state≠SEEK):
  - If line_pix≠0: line_cnt += 1 (saturate at 1023), last_line_pixels ← line_pix; if line_pix≠H_ACTIVE, set frame-local hlen_bad.
  - line_pix ← 0.
  - If a previous HS edge exists in this frame and the HS period counter ≠ H_TOTAL, set htotal_bad.
  - Restart the period counter at 1. It increments every pix_en and saturates at 2047.
- Frame close (VS falling edge):
  - If HS and VS fall on the same sample, the line close is applied first and that line's results are included in the frame.
  - Published values: err_hlen←hlen_bad, err_vlen←(line_cnt≠V_ACTIVE), err_htotal←htotal_bad, active_lines←line_cnt, frame_crc←crc.
  - Then reset the accumulators: CRC←0xFFFF, line_cnt←0, flags←0, period-valid←0.
  - err_sticky |= new flags.
- locked: set after 2 consecutive error-free closed frames; cleared in the same cycle a closed frame has any error.
- Reset, including mid-frame: every output goes to 0 (frame_crc=0x0000, locked=0, err_sticky=0), FSM→SEEK, accumulators cleared.

## Timing
- Outputs are registered. On the clk edge that samples a VS falling edge (pix_en=1), the results load and frame_valid is high for exactly the following clk cycle.
- Published results are stable until the next frame close.
- pix_en=0 cycles change nothing except clearing frame_valid.
- From the first VS edge: the first frame_valid comes at the second VS edge, and locked rises at the third VS edge at the earliest.
- At 640x480@60 the frame period is 800·525 = 420000 pix_en strobes.

## Test plan
- Nominal timing, all pixels 0x000000, 4 frames: frame_valid ×3; active_lines=480; last_line_pixels=640; no errors; locked=1 after the third VS edge; frame_count=3.
- CRC check: single pixel (0,0)=0xFF0000, rest black. frame_crc equals the reference-model CRC and differs from the all-black CRC. Repeating the same frame gives an identical CRC.
- One line with 639 visible pixels: err_hlen=1 that frame, locked drops, err_sticky stays 1. Next clean frame clears err_hlen; locked returns after 2 clean frames.
- Frame with 479 visible lines → err_vlen=1, active_lines=479. One line with H_TOTAL=801 → err_htotal=1.
- HS and VS falling on the same sample at the end of a line: that line is counted in active_lines of the closing frame.
- reset asserted mid-frame for one cycle: all outputs 0, state SEEK. The next VS edge gives no frame_valid; the one after gives a correct frame.

Source files
------------

// File: rtl/vga_frame_checker.sv
// vga_frame_checker
// Passive monitor for a VGA output bus. On every pixel strobe it samples
// HS/VS/BLANK_N and the 24-bit RGB value. It checks line/frame timing and
// builds a per-frame CRC-16-CCITT signature of the visible pixels.
//
// Ports
//   clk, reset           : system clock, synchronous active-high reset
//   i_pix_en             : pixel strobe; every other input is sampled only when high
//   i_vga_hs / i_vga_vs  : syncs, active low (falling edge = line / frame start)
//   i_vga_blank_n        : 1 = visible pixel
//   i_vga_r/g/b          : pixel colour
//   o_frame_valid        : one-clk pulse when the published results update
//   o_frame_crc          : CRC of the last completed frame
//   o_active_lines       : non-empty lines in the last frame
//   o_last_line_pixels   : visible pixel count of the last non-empty line
//   o_frame_count        : completed frames (wraps)
//   o_err_hlen/vlen/htotal : per-frame timing error flags
//   o_err_sticky         : OR of every error flag since reset
//   o_locked             : two or more consecutive clean frames
//   o_dbg_state          : FSM state (0 SEEK, 1 ACQUIRE, 2 RUN)
//
// Handshake: there is no back-pressure. The input bus is valid on every
// clk where i_pix_en=1. o_frame_valid marks the single clk on which the
// newly published results may be captured. The results then hold until
// the next frame close.
module vga_frame_checker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pix_en,
  input  logic        i_vga_hs,
  input  logic        i_vga_vs,
  input  logic        i_vga_blank_n,
  input  logic [7:0]  i_vga_r,
  input  logic [7:0]  i_vga_g,
  input  logic [7:0]  i_vga_b,
  output logic        o_frame_valid,
  output logic [15:0] o_frame_crc,
  output logic [9:0]  o_active_lines,
  output logic [10:0] o_last_line_pixels,
  output logic [15:0] o_frame_count,
  output logic        o_err_hlen,
  output logic        o_err_vlen,
  output logic        o_err_htotal,
  output logic        o_err_sticky,
  output logic        o_locked,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_SEEK    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
  localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
  localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);

  state_t      r_state;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic [10:0] r_line_pix;
  logic [10:0] r_last_pix;
  logic [9:0]  r_line_cnt;
  logic [15:0] r_crc;
  logic        r_hlen_bad;
  logic        r_htotal_bad;
  logic [10:0] r_per_cnt;
  logic        r_per_valid;
  logic [1:0]  r_clean_cnt;

  // Shift the 24 pixel bits, MSB first, through the CCITT polynomial.
  function automatic logic [15:0] crc_fold(input logic [15:0] crc_in,
                                           input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic        w_in_frame;
  logic        w_hs_fall;
  logic        w_vs_fall;
  logic        w_pix;
  logic [10:0] w_line_pix_acc;
  logic [15:0] w_crc_acc;
  logic        w_line_close;
  logic        w_line_nonzero;
  logic [9:0]  w_line_cnt_n;
  logic [10:0] w_last_pix_n;
  logic        w_hlen_n;
  logic        w_htot_n;
  logic        w_vlen_n;
  logic        w_frame_err;
  logic [10:0] w_per_cnt_inc;

  // The values below already include the current sample. A frame close
  // therefore publishes the line close (and any pixel) of the same sample.
  always_comb begin
    w_in_frame     = (r_state != S_SEEK);
    w_hs_fall      = i_pix_en & r_hs_prev & ~i_vga_hs;
    w_vs_fall      = i_pix_en & r_vs_prev & ~i_vga_vs;
    w_pix          = i_pix_en & i_vga_blank_n & w_in_frame;
    w_line_pix_acc = r_line_pix;
    w_crc_acc      = r_crc;
    if (w_pix) begin
      w_line_pix_acc = (r_line_pix == 11'h7FF) ? r_line_pix : r_line_pix + 11'd1;
      w_crc_acc      = crc_fold(r_crc, {i_vga_r, i_vga_g, i_vga_b});
    end
    w_line_close   = w_hs_fall & w_in_frame;
    w_line_nonzero = (w_line_pix_acc != 11'd0);
    w_line_cnt_n   = r_line_cnt;
    w_last_pix_n   = r_last_pix;
    if (w_line_close && w_line_nonzero) begin
      w_line_cnt_n = (r_line_cnt == 10'h3FF) ? r_line_cnt : r_line_cnt + 10'd1;
      w_last_pix_n = w_line_pix_acc;
    end
    w_hlen_n      = r_hlen_bad | (w_line_close & w_line_nonzero & (w_line_pix_acc != H_ACT_L));
    w_htot_n      = r_htotal_bad | (w_line_close & r_per_valid & (r_per_cnt != H_TOT_L));
    w_vlen_n      = (w_line_cnt_n != V_ACT_L);
    w_frame_err   = w_hlen_n | w_vlen_n | w_htot_n;
    w_per_cnt_inc = (r_per_cnt == 11'h7FF) ? r_per_cnt : r_per_cnt + 11'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_SEEK;
      r_hs_prev          <= 1'b1;
      r_vs_prev          <= 1'b1;
      r_line_pix         <= 11'd0;
      r_last_pix         <= 11'd0;
      r_line_cnt         <= 10'd0;
      r_crc              <= 16'hFFFF;
      r_hlen_bad         <= 1'b0;
      r_htotal_bad       <= 1'b0;
      r_per_cnt          <= 11'd0;
      r_per_valid        <= 1'b0;
      r_clean_cnt        <= 2'd0;
      o_frame_valid      <= 1'b0;
      o_frame_crc        <= 16'h0000;
      o_active_lines     <= 10'd0;
      o_last_line_pixels <= 11'd0;
      o_frame_count      <= 16'd0;
      o_err_hlen         <= 1'b0;
      o_err_vlen         <= 1'b0;
      o_err_htotal       <= 1'b0;
      o_err_sticky       <= 1'b0;
      o_locked           <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      if (i_pix_en) begin
        r_hs_prev <= i_vga_hs;
        r_vs_prev <= i_vga_vs;
        r_per_cnt <= w_hs_fall ? 11'd1 : w_per_cnt_inc;
        case (r_state)
          S_SEEK: begin
            if (w_vs_fall) begin
              r_state      <= S_ACQUIRE;
              r_crc        <= 16'hFFFF;
              r_line_cnt   <= 10'd0;
              r_line_pix   <= 11'd0;
              r_hlen_bad   <= 1'b0;
              r_htotal_bad <= 1'b0;
              r_per_valid  <= 1'b0;
            end
          end
          default: begin
            r_line_pix <= w_hs_fall ? 11'd0 : w_line_pix_acc;
            r_last_pix <= w_last_pix_n;
            if (w_vs_fall) begin
              r_state            <= S_RUN;
              o_frame_valid      <= 1'b1;
              o_frame_crc        <= w_crc_acc;
              o_active_lines     <= w_line_cnt_n;
              o_last_line_pixels <= w_last_pix_n;
              o_frame_count      <= o_frame_count + 16'd1;
              o_err_hlen         <= w_hlen_n;
              o_err_vlen         <= w_vlen_n;
              o_err_htotal       <= w_htot_n;
              o_err_sticky       <= o_err_sticky | w_frame_err;
              if (w_frame_err) begin
                r_clean_cnt <= 2'd0;
                o_locked    <= 1'b0;
              end else begin
                r_clean_cnt <= (r_clean_cnt == 2'd2) ? 2'd2 : r_clean_cnt + 2'd1;
                // Locks on the second clean frame in a row.
                if (r_clean_cnt != 2'd0) o_locked <= 1'b1;
              end
              r_crc        <= 16'hFFFF;
              r_line_cnt   <= 10'd0;
              r_hlen_bad   <= 1'b0;
              r_htotal_bad <= 1'b0;
              r_per_valid  <= 1'b0;
            end else begin
              r_crc        <= w_crc_acc;
              r_line_cnt   <= w_line_cnt_n;
              r_hlen_bad   <= w_hlen_n;
              r_htotal_bad <= w_htot_n;
              if (w_hs_fall) r_per_valid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker using a reduced raster (8 visible pixels,
// 14 strobes per line, 4 visible lines) so that many frames fit in a short run.
// Each line: HS low for strobes 0-1, back porch 2-3, visible from strobe 4.
// A "VS line" carries no visible pixels and drops VS at a chosen strobe.
module tb_vga_frame_checker;
  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HT = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hs, vs, bn;
  logic [7:0]  r, g, b;
  logic        o_frame_valid;
  logic [15:0] o_frame_crc;
  logic [9:0]  o_active_lines;
  logic [10:0] o_last_line_pixels;
  logic [15:0] o_frame_count;
  logic        o_err_hlen, o_err_vlen, o_err_htotal, o_err_sticky, o_locked;
  logic [1:0]  o_dbg_state;

  vga_frame_checker #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT)) dut (
    .clk(clk), .reset(reset), .i_pix_en(pix_en),
    .i_vga_hs(hs), .i_vga_vs(vs), .i_vga_blank_n(bn),
    .i_vga_r(r), .i_vga_g(g), .i_vga_b(b),
    .o_frame_valid(o_frame_valid), .o_frame_crc(o_frame_crc),
    .o_active_lines(o_active_lines), .o_last_line_pixels(o_last_line_pixels),
    .o_frame_count(o_frame_count), .o_err_hlen(o_err_hlen),
    .o_err_vlen(o_err_vlen), .o_err_htotal(o_err_htotal),
    .o_err_sticky(o_err_sticky), .o_locked(o_locked), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- reference model state ----------------
  int checks = 0;
  int errors = 0;
  int vis_q[$];            // visible pixels of each line of the open frame
  int tot_q[$];            // strobes per line of the open frame
  logic [23:0] px_q[$];    // visible pixels of the open frame, in raster order
  bit   armed;             // a VS edge has been seen since reset
  int   m_clean;
  int   exp_pulses = 0;
  int   got_pulses = 0;
  logic [15:0] p_crc, p_count, black_crc;
  logic [9:0]  p_act;
  logic [10:0] p_last;
  bit   p_hl, p_vl, p_ht, p_sticky, p_locked;

  always @(negedge clk) if (o_frame_valid === 1'b1) got_pulses++;

  // CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the frame's bit stream.
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        top;
    c = 16'hFFFF;
    foreach (px_q[k]) begin
      for (int i = 23; i >= 0; i--) begin
        top = c[15] ^ px_q[k][i];
        c   = c << 1;
        if (top) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_published();
    chk("frame_crc", o_frame_crc, p_crc);
    chk("active_lines", o_active_lines, p_act);
    chk("last_line_pixels", o_last_line_pixels, p_last);
    chk("frame_count", o_frame_count, p_count);
    chk("err_hlen", o_err_hlen, p_hl);
    chk("err_vlen", o_err_vlen, p_vl);
    chk("err_htotal", o_err_htotal, p_ht);
    chk("err_sticky", o_err_sticky, p_sticky);
    chk("locked", o_locked, p_locked);
  endtask

  task automatic model_clear();
    vis_q.delete(); tot_q.delete(); px_q.delete();
  endtask

  // Called right after the strobe that drops VS has been clocked.
  task automatic close_check();
    int  act;
    bit  err;
    if (!armed) begin
      chk("first_vs_no_valid", o_frame_valid, 1'b0);
      chk("state_acquire", o_dbg_state, 2'd1);
      check_published();
      armed = 1'b1;
    end else begin
      act  = 0;
      p_hl = 1'b0;
      p_ht = 1'b0;
      foreach (vis_q[i]) begin
        if (vis_q[i] != 0) begin
          act++;
          p_last = 11'(vis_q[i]);
          if (vis_q[i] != HA) p_hl = 1'b1;
        end
        if (tot_q[i] != HT) p_ht = 1'b1;
      end
      p_act    = 10'(act);
      p_vl     = (act != VA);
      p_crc    = model_crc();
      p_count  = p_count + 16'd1;
      err      = p_hl | p_vl | p_ht;
      p_sticky = p_sticky | err;
      if (err) m_clean = 0; else m_clean++;
      p_locked = (m_clean >= 2);
      exp_pulses++;
      chk("frame_valid", o_frame_valid, 1'b1);
      chk("state_run", o_dbg_state, 2'd2);
      check_published();
    end
    model_clear();
  endtask

  // ---------------- driver tasks ----------------
  task automatic samp(input logic h, input logic v, input logic blank, input logic [23:0] rgb);
    @(negedge clk);
    hs = h; vs = v; bn = blank; {r, g, b} = rgb; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  // mode: 0 all black, 1 single red pixel at (0,0), 2 random colours
  task automatic send_line(input int vis, input int total, input int vs_at,
                           input int mode, input bit content);
    int          idx;
    logic        h, v, blank;
    logic [23:0] rgb;
    idx = vis_q.size();
    for (int s = 0; s < total; s++) begin
      h     = (s >= 2);
      v     = !(vs_at >= 0 && s >= vs_at);
      blank = (s >= 4 && s < 4 + vis);
      rgb   = 24'h000000;
      if (blank) begin
        if (mode == 1 && idx == 0 && s == 4) rgb = 24'hFF0000;
        else if (mode == 2) rgb = 24'($urandom);
        if (content) px_q.push_back(rgb);
      end
      samp(h, v, blank, rgb);
      if (s == vs_at) close_check();
    end
    if (content) begin
      vis_q.push_back(vis);
      tot_q.push_back(total);
    end
  endtask

  task automatic vs_line(input int vs_at);
    send_line(0, HT, vs_at, 0, 1'b0);
  endtask

  task automatic frame(input int n_vis, input int mode, input int short_i,
                       input int long_i, input int n_blank);
    for (int i = 0; i < n_vis; i++)
      send_line((i == short_i) ? HA - 1 : HA, (i == long_i) ? HT + 1 : HT, -1, mode, 1'b1);
    for (int i = 0; i < n_blank; i++)
      send_line(0, HT, -1, 0, 1'b1);
    chk("stable_valid_low", o_frame_valid, 1'b0);
    chk("stable_crc", o_frame_crc, p_crc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b0; m_clean = 0;
    p_crc = 16'h0; p_count = 16'h0; p_act = 10'h0; p_last = 11'h0;
    p_hl = 1'b0; p_vl = 1'b0; p_ht = 1'b0; p_sticky = 1'b0; p_locked = 1'b0;
    model_clear();
    chk("reset_valid", o_frame_valid, 1'b0);
    chk("reset_state", o_dbg_state, 2'd0);
    check_published();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; bn = 1'b0;
    r = 8'h0; g = 8'h0; b = 8'h0;
    repeat (3) @(negedge clk);
    do_reset();

    // Nominal black frames: valid at VS #2..#4, locked from VS #3.
    vs_line(6);
    frame(VA, 0, -1, -1, 1); vs_line(6);
    black_crc = p_crc;
    frame(VA, 0, -1, -1, 1); vs_line(6);
    frame(VA, 0, -1, -1, 1); vs_line(6);

    // Single red pixel, twice.
    frame(VA, 1, -1, -1, 1); vs_line(6);
    chk("crc_differs_from_black", (o_frame_crc != black_crc), 1'b1);
    frame(VA, 1, -1, -1, 1); vs_line(6);

    // Random colours.
    frame(VA, 2, -1, -1, 1); vs_line(6);

    // Short line, then recovery over two clean frames.
    frame(VA, 2, 1, -1, 1); vs_line(6);
    frame(VA, 2, -1, -1, 1); vs_line(6);
    frame(VA, 2, -1, -1, 1); vs_line(6);

    // Missing line, then one over-long line.
    frame(VA - 1, 2, -1, -1, 1); vs_line(6);
    frame(VA, 2, -1, 2, 1); vs_line(6);

    // Last visible line closed by an HS that coincides with VS.
    frame(VA, 2, -1, -1, 0); vs_line(0);
    frame(VA, 2, -1, -1, 1); vs_line(6);

    // Reset in the middle of a frame.
    send_line(HA, HT, -1, 2, 1'b1);
    send_line(HA, HT, -1, 2, 1'b1);
    do_reset();
    send_line(HA, HT, -1, 2, 1'b1);
    send_line(HA, HT, -1, 2, 1'b1);
    vs_line(6);
    frame(VA, 2, -1, -1, 1); vs_line(6);

    repeat (4) @(negedge clk);
    chk("frame_valid_pulse_count", got_pulses, exp_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
